// File: rtl/barrelshifter_pkg.sv
// barrelshifter_pkg: shared types, widths and op decode for barrelshifter_ctrl
// Optional feature macro: BARREL_ROTATE_EN (sll+srl with sra=0 becomes rotate-left)
package barrelshifter_pkg;
    typedef enum logic [2:0] {OP_NONE, OP_SRA, OP_SRL, OP_SLL, OP_ROL} shift_op_t;
    localparam int CHUNK_W = 5;
    localparam int SHAMT_W = 3;
`ifdef BARREL_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif
    // Priority sra > srl > sll; the rotate combination only exists with the macro.
    function automatic shift_op_t decode_op(input logic sra, input logic srl, input logic sll);
        return sra ? OP_SRA : (srl && sll && ROT_EN) ? OP_ROL : srl ? OP_SRL : sll ? OP_SLL : OP_NONE;
    endfunction
endpackage

// File: rtl/barrelshifter_ctrl_btn_edge_sync.sv
// btn_edge_sync: STAGES-flop synchronizer followed by a rising-edge one-cycle pulse
// Ports: clk_i clock, rst_ni sync active-low reset, btn_i async button level, pulse_o 1-cycle pulse per 0->1
module btn_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic pulse_o
);
    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q;
    assign sync_d  = STAGES'({sync_q, btn_i});
    assign pulse_o = sync_q[STAGES-1] & ~prev_q;
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[STAGES-1];
        end
    end
endmodule

// File: rtl/barrelshifter_ctrl.sv
// barrelshifter_ctrl: button-driven operand register with 3-stage log barrel shifter
// Ports: clk, rst_n (sync active-low), number shift amount, sra/srl/sll op select,
//        data_in load chunk, input_a load button, input_b shift button, data_out low nibble
// Optional feature macro: BARREL_ROTATE_EN
module barrelshifter_ctrl
    import barrelshifter_pkg::*;
#(
    parameter int DATA_W      = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SHAMT_W-1:0] number,
    input  logic               sra,
    input  logic               srl,
    input  logic               sll,
    input  logic [CHUNK_W-1:0] data_in,
    input  logic               input_a,
    input  logic               input_b,
    output logic [3:0]         data_out
);
    logic                           load_p, shift_p;
    logic [DATA_W-1:0]              value_q, value_d;
    logic [SHAMT_W:0][DATA_W-1:0]   st;
    shift_op_t                      op;

    btn_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_a (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .btn_i  (input_a),
        .pulse_o(load_p)
    );

    btn_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_b (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .btn_i  (input_b),
        .pulse_o(shift_p)
    );

    assign op    = decode_op(sra, srl, sll);
    assign st[0] = value_q;

    // Stage i shifts by 2**i when number[i] is set.
    for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
        localparam int K = 1 << i;
        logic [DATA_W-1:0] x;
        assign x = st[i];
        assign st[i+1] = !number[i]   ? x :
                         op == OP_SRA ? {{K{x[DATA_W-1]}}, x[DATA_W-1:K]} :
                         op == OP_SRL ? {{K{1'b0}}, x[DATA_W-1:K]} :
                         op == OP_SLL ? {x[DATA_W-1-K:0], {K{1'b0}}} :
                         op == OP_ROL ? {x[DATA_W-1-K:0], x[DATA_W-1:DATA_W-K]} : x;
    end

    // Load wins over a coincident shift.
    assign value_d = load_p  ? {value_q[DATA_W-CHUNK_W-1:0], data_in} :
                     shift_p ? st[SHAMT_W] : value_q;

    always_ff @(posedge clk) begin
        if (!rst_n) value_q <= '0;
        else        value_q <= value_d;
    end

    assign data_out = value_q[3:0];
endmodule

// File: tb/tb_barrelshifter_ctrl.sv
// tb_barrelshifter_ctrl: scoreboard bench with directed and random button events
module tb_barrelshifter_ctrl;
    localparam int W = 20;
`ifdef BARREL_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] number = '0;
    logic       sra = 1'b0, srl = 1'b0, sll = 1'b0;
    logic [4:0] data_in = '0;
    logic       input_a = 1'b0, input_b = 1'b0;
    logic [3:0] data_out;

    barrelshifter_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .number  (number),
        .sra     (sra),
        .srl     (srl),
        .sll     (sll),
        .data_in (data_in),
        .input_a (input_a),
        .input_b (input_b),
        .data_out(data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           due;
        logic [W-1:0] v;
    } exp_t;

    exp_t         q[$];
    int           cyc = 0;
    int           n_cmp = 0, n_err = 0;
    bit           mon_on = 1'b0;
    logic [W-1:0] cur = '0, model = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: every cycle the register must hold the latest expectation whose due cycle has come.
    always @(negedge clk) begin
        if (mon_on) begin
            if (q.size() > 0 && q[0].due <= cyc) cur = q.pop_front().v;
            check("value_q", dut.value_q, cur);
            check("data_out", W'(data_out), W'(cur[3:0]));
        end
    end

    // Reference: shifts expressed as multiply/divide by powers of two.
    function automatic logic [W-1:0] mdl_shift(input logic [W-1:0] v, input int n,
                                               input bit ra, input bit rl, input bit ll);
        longint x = longint'(v);
        longint p = longint'(1) << n;
        longint m = longint'(1) << W;
        if (n == 0) return v;
        if (ra) return W'(x / p + (v[W-1] ? m - (m >> n) : 64'd0));
        if (rl && ll && ROT) return W'((x * p) % m + x / (m / p));
        if (rl) return W'(x / p);
        if (ll) return W'((x * p) % m);
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic press(input bit a, input bit b, input logic [4:0] d, input int n,
                         input bit ra, input bit rl, input bit ll, input int hold);
        input_a = a;
        input_b = b;
        data_in = d;
        number  = 3'(n);
        sra = ra;
        srl = rl;
        sll = ll;
        if (a) model = {model[W-6:0], d};
        else if (b) model = mdl_shift(model, n, ra, rl, ll);
        q.push_back('{cyc + 3, model});
        repeat (hold) tick;
        input_a = 1'b0;
        input_b = 1'b0;
        sra = 1'b0;
        srl = 1'b0;
        sll = 1'b0;
        repeat (3) tick;
    endtask

    task automatic load4(input logic [4:0] c0, input logic [4:0] c1,
                         input logic [4:0] c2, input logic [4:0] c3);
        press(1, 0, c0, 0, 0, 0, 0, 3);
        press(1, 0, c1, 0, 0, 0, 0, 3);
        press(1, 0, c2, 0, 0, 0, 0, 3);
        press(1, 0, c3, 0, 0, 0, 0, 3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1);
    end

    initial begin
        tick;
        mon_on = 1'b1;
        q.push_back('{cyc + 1, W'(0)});
        for (int i = 0; i < 3; i++) begin
            input_a = ~input_a;
            input_b = ~input_b;
            data_in = 5'h1F;
            tick;
        end
        input_a = 1'b0;
        input_b = 1'b0;
        rst_n = 1'b1;
        repeat (5) tick;
        check("reset", dut.value_q, W'(0));

        load4(5'h01, 5'h02, 5'h03, 5'h04);
        check("load", dut.value_q, 20'h08864);
        press(0, 1, 0, 4, 0, 1, 0, 20);
        check("srl4", dut.value_q, 20'h00886);
        load4(5'h01, 5'h02, 5'h03, 5'h04);
        press(0, 1, 0, 3, 0, 0, 1, 3);
        check("sll3", dut.value_q, 20'h44320);

        load4(5'h10, 5'h00, 5'h00, 5'h00);
        check("load_neg", dut.value_q, 20'h80000);
        press(0, 1, 0, 7, 1, 0, 0, 3);
        check("sra7", dut.value_q, 20'hFF000);
        load4(5'h10, 5'h00, 5'h00, 5'h00);
        press(0, 1, 0, 7, 0, 1, 0, 3);
        check("srl7", dut.value_q, 20'h01000);
        press(0, 1, 0, 0, 1, 0, 0, 3);
        press(0, 1, 0, 0, 0, 0, 1, 3);
        press(0, 1, 0, 5, 0, 0, 0, 3);
        check("n0_noop", dut.value_q, 20'h01000);

        press(1, 1, 5'h1F, 3, 1, 1, 0, 3);
        check("conflict", dut.value_q, 20'h2001F);
        press(0, 1, 0, 1, 1, 1, 0, 3);
        check("sra_over_srl", dut.value_q, 20'h1000F);

        load4(5'h10, 5'h00, 5'h00, 5'h01);
        press(0, 1, 0, 1, 0, 1, 1, 3);
        check("rol_combo", dut.value_q, ROT ? 20'h00003 : 20'h40000);

        // Reset while a load is still in the synchronizer: the load must vanish.
        input_a = 1'b1;
        data_in = 5'h15;
        tick;
        rst_n = 1'b0;
        model = '0;
        q.push_back('{cyc + 1, W'(0)});
        tick;
        tick;
        input_a = 1'b0;
        tick;
        rst_n = 1'b1;
        repeat (5) tick;
        check("reset_inflight", dut.value_q, W'(0));

        for (int i = 0; i < 60; i++) begin
            int k;
            k = $urandom_range(0, 9);
            press(k < 4 || k == 9, k >= 4, 5'($urandom), $urandom_range(0, 7),
                  1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(3, 6));
        end

        repeat (4) tick;
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/barrelshifter_ctrl.md
Name: barrelshifter_ctrl

Overview:
Board-level 20-bit barrel shifter with an operand register.
- Push-button input_a loads 5-bit switch chunks (data_in) into the register.
- Push-button input_b applies one shift (arithmetic right, logical right or logical left) by 0..7 positions, selected by the sra/srl/sll switches and number.
- The low nibble of the register drives four LEDs (data_out).

Parameters:
DATA_W, 20, operand register width; must be a multiple of 5 and at least 8.
SYNC_STAGES, 2, synchronizer flops per button input.

Ports:
clk  input  1  single system clock; all logic on rising edge.
rst_n  input  1  synchronous active-low reset.
number  input  3  shift amount, 0..7.
sra  input  1  select arithmetic right shift.
srl  input  1  select logical right shift.
sll  input  1  select logical left shift.
data_in  input  5  chunk shifted into the register on a load.
input_a  input  1  load button, asynchronous level input.
input_b  input  1  shift button, asynchronous level input.
data_out  output  4  value_q[3:0], driven directly from register bits.

Behaviour:
- Reset, when rst_n is low at a clk edge:
  - value_q = 0, all synchronizer and edge-detect flops = 0, so data_out = 0.
  - Any event in flight is discarded.
- Button path:
  - input_a and input_b each pass through SYNC_STAGES flops, then a rising-edge detector.
  - Each 0->1 transition yields exactly one 1-cycle pulse (load_p or shift_p). Holding a button high causes no repeats.
  - Latency with SYNC_STAGES=2: the input is first sampled high at edge k; value_q updates at edge k+2; data_out shows the new value after edge k+2.
- Load (load_p): value_q <= {value_q[DATA_W-6:0], data_in}. The oldest chunk falls off the top.
- Shift (shift_p), with amount n = number and op decoded by priority sra > srl > sll:
  - sra: value_q >>> n, replicating bit DATA_W-1.
  - srl: value_q >> n, zero fill.
  - sll: value_q << n, zero fill, bits shifted past the MSB are lost.
  - No op bit set: value_q unchanged.
  - n = 0: value_q unchanged for every op.
- Datapath and sampling:
  - Combinational 3-stage log shifter (shift by 1, 2, 4), muxed by number bits.
  - number, sra, srl, sll and data_in are sampled in the same cycle as the pulse.
- Simultaneous load_p and shift_p in the same cycle: the load executes and the shift is dropped.
- No other state, no handshake; data_out is always valid.

Optional Feature:
BARREL_ROTATE_EN
- Defined: sll=1 and srl=1 with sra=0 performs rotate-left by n, i.e. value_q <= (value_q << n) | (value_q >> (DATA_W-n)).
- Not defined: that combination is a plain srl per the priority rule.
- All other combinations behave identically with or without the macro.

Decomposition:
- Package barrelshifter_pkg holds:
  - enum shift_op_t {OP_NONE, OP_SRA, OP_SRL, OP_SLL, OP_ROL};
  - localparam CHUNK_W=5 and SHAMT_W=3;
  - the op-decode function (sra/srl/sll -> shift_op_t).
- One sub-module, btn_edge_sync: synchronizer plus rising-edge pulse, instantiated once each for input_a and input_b.
- The shifter core stays inline.

Test Plan:
1. Reset: hold rst_n low for 3 cycles with buttons toggling -> value_q=0 and data_out=0; no pulse is taken within 3 cycles after release.
2. Load: pulse input_a with data_in 0x01, 0x02, 0x03, 0x04 in turn -> value_q=0x08864, data_out=4'h4. Each update lands exactly 2 edges after the first high sample.
3. Right shift: from 0x08864, srl=1, number=4, pulse input_b -> 0x00886, data_out=4'h6. Holding input_b high for 20 cycles causes no further change.
4. Left shift: reload 0x08864, sll=1, number=3 -> 0x44320, data_out=4'h0.
5. Arithmetic vs logical: load 0x10, 0x00, 0x00, 0x00 giving value_q=0x80000.
   - sra=1, number=7 -> 0xFF000.
   - Reload 0x80000; sra=0, srl=1, number=7 -> 0x01000.
   - Any op with number=0 -> unchanged.
6. Conflicts: input_a and input_b rise on the same cycle with data_in=0x1F -> load only (value_q = {old[14:0], 5'h1F}).
   - With sra=1 and srl=1 -> sra result.
   - With BARREL_ROTATE_EN: 0x80001, sll=srl=1, number=1 -> 0x00003.
